// File: rtl/mem_pkg.sv
// Shared opcodes, FSM state type and parameter defaults for the memory stage.
package mem_pkg;

  localparam logic [3:0] OP_LW = 4'b1000;
  localparam logic [3:0] OP_SW = 4'b1001;

  localparam int unsigned DATA_W_DEF   = 16;
  localparam int unsigned ADDR_W_DEF   = 16;
  localparam int unsigned SB_DEPTH_DEF = 4;
  localparam int unsigned REG_W_DEF    = 4;

  typedef enum logic {
    IDLE,
    LOAD_WAIT
  } state_e;

endpackage

// File: rtl/mem_stage_sb_if.sv
// Memory-side request/response bus; master = memory stage, slave = memory.
interface mem_stage_sb_if #(
  parameter int unsigned DATA_W = mem_pkg::DATA_W_DEF,
  parameter int unsigned ADDR_W = mem_pkg::ADDR_W_DEF
) ();

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic              mem_rsp_valid;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ready, mem_rsp_valid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ready, mem_rsp_valid, mem_rdata
  );

endinterface

// File: rtl/store_buffer.sv
// In-order circular store buffer with youngest-match address lookup.
// MEM_STORE_FWD_EN adds the matched-data output used for load forwarding.
module store_buffer import mem_pkg::*; #(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DEPTH  = SB_DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enq_i,
  input  logic [ADDR_W-1:0]          enq_addr_i,
  input  logic [DATA_W-1:0]          enq_data_i,
  input  logic                       deq_i,
  input  logic [ADDR_W-1:0]          lookup_addr_i,
  output logic                       hit_o,
`ifdef MEM_STORE_FWD_EN
  output logic [DATA_W-1:0]          hit_data_o,
`endif
  output logic                       full_o,
  output logic                       empty_o,
  output logic [ADDR_W-1:0]          head_addr_o,
  output logic [DATA_W-1:0]          head_data_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d, idx;
  logic [CNT_W-1:0]  count_q, count_d;

  always_comb begin
    head_d  = deq_i ? head_q + PTR_W'(1) : head_q;
    tail_d  = enq_i ? tail_q + PTR_W'(1) : tail_q;
    count_d = count_q;
    if (enq_i && !deq_i) count_d = count_q + CNT_W'(1);
    if (!enq_i && deq_i) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq_i) begin
      addr_q[tail_q] <= enq_addr_i;
      data_q[tail_q] <= enq_data_i;
    end
  end

  // Walk oldest to youngest so the last hit wins.
  always_comb begin
    hit_o = 1'b0;
`ifdef MEM_STORE_FWD_EN
    hit_data_o = '0;
`endif
    idx = head_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head_q + PTR_W'(i);
      if ((CNT_W'(i) < count_q) && (addr_q[idx] == lookup_addr_i)) begin
        hit_o = 1'b1;
`ifdef MEM_STORE_FWD_EN
        hit_data_o = data_q[idx];
`endif
      end
    end
  end

  assign full_o      = (count_q == CNT_W'(DEPTH));
  assign empty_o     = (count_q == '0);
  assign head_addr_o = addr_q[head_q];
  assign head_data_o = data_q[head_q];
  assign count_o     = count_q;

endmodule

// File: rtl/mem_stage_sb.sv
// Pipeline memory stage with a store buffer draining to a single-request memory bus.
// MEM_STORE_FWD_EN: matching loads are served from the buffer instead of stalling.
module mem_stage_sb import mem_pkg::*; #(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned SB_DEPTH = SB_DEPTH_DEF,
  parameter int unsigned REG_W    = REG_W_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          mem_en,
  input  logic                          mem_wr,
  input  logic [3:0]                    opcode,
  input  logic [3:0]                    wb_opcode,
  input  logic [REG_W-1:0]              src_reg,
  input  logic [DATA_W-1:0]             reg_read,
  input  logic [REG_W-1:0]              wb_reg_write,
  input  logic [DATA_W-1:0]             wb_mem_out,
  input  logic [ADDR_W-1:0]             alu_out,
  mem_stage_sb_if.master                mem,
  output logic [DATA_W-1:0]             mem_out,
  output logic                          stall,
  output logic [$clog2(SB_DEPTH+1)-1:0] sb_count
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] store_data;
  logic              sb_enq, sb_deq, sb_hit, sb_full, sb_empty, load_req;
  logic [ADDR_W-1:0] sb_head_addr;
  logic [DATA_W-1:0] sb_head_data;
`ifdef MEM_STORE_FWD_EN
  logic [DATA_W-1:0] sb_hit_data;
`endif

  assign store_data = (opcode == OP_SW && wb_opcode == OP_LW && wb_reg_write == src_reg)
                      ? wb_mem_out : reg_read;

  store_buffer #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (SB_DEPTH)
  ) u_sb (
    .clk           (clk),
    .rst           (rst),
    .enq_i         (sb_enq),
    .enq_addr_i    (alu_out),
    .enq_data_i    (store_data),
    .deq_i         (sb_deq),
    .lookup_addr_i (alu_out),
    .hit_o         (sb_hit),
`ifdef MEM_STORE_FWD_EN
    .hit_data_o    (sb_hit_data),
`endif
    .full_o        (sb_full),
    .empty_o       (sb_empty),
    .head_addr_o   (sb_head_addr),
    .head_data_o   (sb_head_data),
    .count_o       (sb_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Outputs are combinational, so they are forced to their idle values while reset is held.
  always_comb begin
    state_d       = state_q;
    mem.mem_req   = 1'b0;
    mem.mem_we    = 1'b0;
    mem.mem_addr  = sb_head_addr;
    mem.mem_wdata = sb_head_data;
    mem_out       = '0;
    stall         = 1'b0;
    sb_enq        = 1'b0;
    sb_deq        = 1'b0;
    load_req      = 1'b0;
    if (rst) begin
      if (mem_en && mem_wr) begin
        if (sb_full) stall  = 1'b1;
        else         sb_enq = 1'b1;
      end
      if (state_q == IDLE) begin
        if (mem_en && !mem_wr) begin
`ifdef MEM_STORE_FWD_EN
          if (sb_hit) mem_out  = sb_hit_data;
          else        load_req = 1'b1;
`else
          if (sb_hit) stall    = 1'b1;
          else        load_req = 1'b1;
`endif
        end
        if (load_req) begin
          mem.mem_req  = 1'b1;
          mem.mem_addr = alu_out;
          stall        = 1'b1;
          if (mem.mem_ready) state_d = LOAD_WAIT;
        end else if (!sb_empty) begin
          mem.mem_req = 1'b1;
          mem.mem_we  = 1'b1;
          sb_deq      = mem.mem_ready;
        end
      end else begin
        if (mem.mem_rsp_valid) begin
          mem_out = mem.mem_rdata;
          state_d = IDLE;
        end else begin
          stall = mem_en;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_sb.sv
// Scoreboard bench for mem_stage_sb: random loads/stores against a flat-memory reference.
module tb_mem_stage_sb;

  localparam int DW = 16, AW = 16, DEPTH = 4, RW = 4;
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [3:0] T_LW = 4'b1000, T_SW = 4'b1001;

  logic          clk = 1'b0;
  logic          rst;
  logic          mem_en, mem_wr;
  logic [3:0]    opcode, wb_opcode;
  logic [RW-1:0] src_reg, wb_reg_write;
  logic [DW-1:0] reg_read, wb_mem_out, mem_out;
  logic [AW-1:0] alu_out;
  logic          stall;
  logic [CW-1:0] sb_count;

  always #5 clk = ~clk;

  mem_stage_sb_if #(.DATA_W(DW), .ADDR_W(AW)) mem_bus ();

  mem_stage_sb #(.DATA_W(DW), .ADDR_W(AW), .SB_DEPTH(DEPTH), .REG_W(RW)) dut (
    .clk(clk), .rst(rst), .mem_en(mem_en), .mem_wr(mem_wr), .opcode(opcode),
    .wb_opcode(wb_opcode), .src_reg(src_reg), .reg_read(reg_read),
    .wb_reg_write(wb_reg_write), .wb_mem_out(wb_mem_out), .alu_out(alu_out),
    .mem(mem_bus), .mem_out(mem_out), .stall(stall), .sb_count(sb_count)
  );

  typedef struct packed { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;

  int tests = 0, fails = 0;
  wr_t           exp_wr_q[$];
  logic [DW-1:0] exp_ld_q[$];
  logic [DW-1:0] ref_mem  [logic [AW-1:0]];
  logic [DW-1:0] phys_mem [logic [AW-1:0]];

  int            ready_mode = 0;  // 0 low, 1 high, 2 random
  int            lat_fix    = 0;  // 0 = random latency 1..4
  bit            rd_pend    = 0;
  int            rd_cnt     = 0;
  logic [AW-1:0] rd_addr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return a ^ 16'hA5C3;
  endfunction

  function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  function automatic logic [DW-1:0] phys_read(input logic [AW-1:0] a);
    return phys_mem.exists(a) ? phys_mem[a] : init_val(a);
  endfunction

  // Memory model: ready and responses driven 2 time units after the rising edge.
  initial begin
    mem_bus.mem_ready     = 1'b0;
    mem_bus.mem_rsp_valid = 1'b0;
    mem_bus.mem_rdata     = '0;
    forever begin
      @(posedge clk); #2;
      mem_bus.mem_rsp_valid = 1'b0;
      mem_bus.mem_rdata     = 16'($urandom);
      if (rd_pend) begin
        rd_cnt--;
        if (rd_cnt <= 0) begin
          mem_bus.mem_rsp_valid = 1'b1;
          mem_bus.mem_rdata     = phys_read(rd_addr);
          rd_pend               = 0;
        end
      end
      case (ready_mode)
        0:       mem_bus.mem_ready = 1'b0;
        1:       mem_bus.mem_ready = 1'b1;
        default: mem_bus.mem_ready = ($urandom_range(0, 1) == 1);
      endcase
    end
  end

  // Monitor: compares every drained write and every completed load with the scoreboard.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (rd_pend || mem_bus.mem_rsp_valid) check("one_outstanding", mem_bus.mem_req, 1'b0);
      if (mem_bus.mem_req && mem_bus.mem_we && mem_bus.mem_ready) begin
        if (exp_wr_q.size() == 0) check("unexpected_write", 1, 0);
        else begin
          wr_t w;
          w = exp_wr_q.pop_front();
          check("drain_addr", mem_bus.mem_addr, w.a);
          check("drain_data", mem_bus.mem_wdata, w.d);
        end
        phys_mem[mem_bus.mem_addr] = mem_bus.mem_wdata;
      end
      if (mem_bus.mem_req && !mem_bus.mem_we && mem_bus.mem_ready) begin
        int hits = 0;
        foreach (exp_wr_q[i]) if (exp_wr_q[i].a == mem_bus.mem_addr) hits++;
        check("read_no_buffered_match", hits, 0);
        rd_pend = 1;
        rd_addr = mem_bus.mem_addr;
        rd_cnt  = (lat_fix != 0) ? lat_fix : int'($urandom_range(1, 4));
      end
      if (mem_en && !mem_wr && !stall) begin
        if (exp_ld_q.size() == 0) check("unexpected_load", 1, 0);
        else check("load_data", mem_out, exp_ld_q.pop_front());
      end else begin
        check("idle_mem_out", mem_out, 0);
      end
      if (!mem_en) check("stall_no_access", stall, 0);
    end
  end

  task automatic present(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] rd,
                         input logic [3:0] op, input logic [3:0] wop, input logic [RW-1:0] src,
                         input logic [RW-1:0] wreg, input logic [DW-1:0] wbv);
    logic [DW-1:0] sd;
    mem_en = 1'b1; mem_wr = wr; alu_out = a; reg_read = rd; opcode = op;
    wb_opcode = wop; src_reg = src; wb_reg_write = wreg; wb_mem_out = wbv;
    if (wr) begin
      sd = (op == T_SW && wop == T_LW && wreg == src) ? wbv : rd;
      exp_wr_q.push_back('{a: a, d: sd});
      ref_mem[a] = sd;
    end else begin
      exp_ld_q.push_back(ref_read(a));
    end
  endtask

  task automatic wait_accept();
    int n = 0;
    @(negedge clk);
    while (stall && n < 300) begin
      n++;
      @(negedge clk);
    end
    check("accept_timeout", stall, 0);
    @(posedge clk); #1;
  endtask

  task automatic issue(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] rd,
                       input logic [3:0] op, input logic [3:0] wop, input logic [RW-1:0] src,
                       input logic [RW-1:0] wreg, input logic [DW-1:0] wbv);
    present(wr, a, rd, op, wop, src, wreg, wbv);
    wait_accept();
    mem_en = 1'b0;
  endtask

  task automatic idle(input int n);
    mem_en = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain_all();
    int n = 0;
    ready_mode = 1;
    @(negedge clk);
    while (sb_count != 0 && n < 100) begin n++; @(negedge clk); end
    check("drain_empty", sb_count, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b0; mem_en = 1'b0; mem_wr = 1'b0; opcode = '0; wb_opcode = '0;
    src_reg = '0; wb_reg_write = '0; reg_read = '0; wb_mem_out = '0; alu_out = '0;

    // Reset state, with a load presented while reset is held.
    repeat (2) @(posedge clk);
    #1; mem_en = 1'b1; alu_out = 16'h0033;
    @(negedge clk);
    check("rst_count", sb_count, 0);
    check("rst_stall", stall, 0);
    check("rst_mem_out", mem_out, 0);
    check("rst_mem_req", mem_bus.mem_req, 0);
    check("rst_mem_we", mem_bus.mem_we, 0);
    @(posedge clk); #1; mem_en = 1'b0; rst = 1'b1;
    idle(2);

    // Fill the buffer, stall the fifth store, release one slot.
    ready_mode = 0;
    for (int i = 0; i < 4; i++)
      issue(1, 16'h0010 + 16'(i), 16'h0100 + 16'(i), T_SW, 4'h0, 4'd1, 4'd2, 16'h0);
    present(1, 16'h0014, 16'h0114, T_SW, 4'h0, 4'd1, 4'd2, 16'h0);
    @(negedge clk);
    check("full_count", sb_count, 4);
    check("full_stall", stall, 1);
    check("drain_head_addr", mem_bus.mem_addr, 16'h0010);
    ready_mode = 1;
    @(posedge clk); #3; ready_mode = 0;
    @(negedge clk);
    check("stall_during_deq", stall, 1);
    check("count_during_deq", sb_count, 4);
    @(negedge clk);
    check("count_after_deq", sb_count, 3);
    check("stall_released", stall, 0);
    @(posedge clk); #1; mem_en = 1'b0;
    @(negedge clk);
    check("count_after_enq", sb_count, 4);
    @(posedge clk); #1;
    drain_all();

    // Two stores to one address, then a load of it.
    ready_mode = 0;
    issue(1, 16'h0020, 16'hBEEF, T_SW, 4'h0, 4'd1, 4'd2, 16'h0);
    issue(1, 16'h0020, 16'h1234, T_SW, 4'h0, 4'd1, 4'd2, 16'h0);
    present(0, 16'h0020, 16'h0, T_LW, 4'h0, 4'd0, 4'd0, 16'h0);
    @(negedge clk);
`ifdef MEM_STORE_FWD_EN
    check("fwd_stall", stall, 0);
    check("fwd_data", mem_out, 16'h1234);
    @(posedge clk); #1; mem_en = 1'b0;
`else
    check("match_stall", stall, 1);
    ready_mode = 2;
    wait_accept();
    mem_en = 1'b0;
`endif
    drain_all();

    // Non-matching load with 3-cycle response latency.
    lat_fix = 3;
    phys_mem[16'h0040] = 16'hCAFE;
    ref_mem[16'h0040]  = 16'hCAFE;
    present(0, 16'h0040, 16'h0, T_LW, 4'h0, 4'd0, 4'd0, 16'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("load_wait_stall", stall, 1);
    end
    @(negedge clk);
    check("load_done_stall", stall, 0);
    check("load_done_data", mem_out, 16'hCAFE);
    @(posedge clk); #1; mem_en = 1'b0;

    // Store data taken from the write-back load.
    ready_mode = 0;
    issue(1, 16'h0050, 16'h0001, T_SW, T_LW, 4'd5, 4'd5, 16'h7777);
    check("wb_fwd_model", exp_wr_q[exp_wr_q.size()-1].d, 16'h7777);
    issue(1, 16'h0051, 16'h0001, T_SW, T_LW, 4'd5, 4'd6, 16'h7777);
    drain_all();

    // Reset while a load is outstanding with two stores buffered.
    ready_mode = 0;
    issue(1, 16'h0060, 16'h6060, T_SW, 4'h0, 4'd1, 4'd2, 16'h0);
    issue(1, 16'h0061, 16'h6161, T_SW, 4'h0, 4'd1, 4'd2, 16'h0);
    present(0, 16'h0070, 16'h0, T_LW, 4'h0, 4'd0, 4'd0, 16'h0);
    @(negedge clk);
    check("load_priority_req", mem_bus.mem_req, 1);
    check("load_priority_we", mem_bus.mem_we, 0);
    ready_mode = 1;
    @(posedge clk); #3; ready_mode = 0;
    @(negedge clk);
    @(negedge clk);
    check("load_wait_no_req", mem_bus.mem_req, 0);
    check("load_wait_count", sb_count, 2);
    #1; rst = 1'b0; mem_en = 1'b0;
    exp_wr_q.delete(); exp_ld_q.delete();
    ref_mem = phys_mem;
    #1;
    check("arst_count", sb_count, 0);
    check("arst_mem_req", mem_bus.mem_req, 0);
    check("arst_stall", stall, 0);
    @(posedge clk); #1; rst = 1'b1;
    begin
      int n = 0;
      @(negedge clk);
      while (!mem_bus.mem_rsp_valid && n < 10) begin n++; @(negedge clk); end
      check("late_rsp_seen", mem_bus.mem_rsp_valid, 1);
      check("late_rsp_mem_out", mem_out, 0);
      check("late_rsp_stall", stall, 0);
    end
    @(posedge clk); #1;
    lat_fix = 0; ready_mode = 2;
    issue(0, 16'h0071, 16'h0, T_LW, 4'h0, 4'd0, 4'd0, 16'h0);

    // Random traffic over a small address pool to exercise matches and forwarding.
    for (int k = 0; k < 250; k++) begin
      logic [AW-1:0] a;
      logic [3:0] op, wop;
      a = 16'h0080 + 16'($urandom_range(0, 7));
      if ($urandom_range(0, 9) < 5) begin
        op  = ($urandom_range(0, 3) != 0) ? T_SW : 4'($urandom_range(0, 15));
        wop = ($urandom_range(0, 1) == 1) ? T_LW : 4'($urandom_range(0, 15));
        issue(1, a, 16'($urandom), op, wop, 4'($urandom_range(0, 3)),
              4'($urandom_range(0, 3)), 16'($urandom));
      end else begin
        issue(0, a, 16'($urandom), T_LW, 4'($urandom), 4'($urandom), 4'($urandom), 16'($urandom));
      end
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 4)));
    end
    drain_all();
    idle(8);
    check("end_writes_pending", exp_wr_q.size(), 0);
    check("end_loads_pending", exp_ld_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
